coin_return_dispenser: RTL and testbench



---
 rtl/coin_return_dispenser_if.sv | 42 ++++
 rtl/coin_return_dispenser.sv | 136 +++++++++++++
 tb/tb_coin_return_dispenser.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_return_dispenser_if.sv
// Bus between the vending-machine calculator and the coin return stage.
// The master side is upstream (coin/select/return inputs and balance); the slave side is the
// return stage, which drives the timer, the coin stream and the return status.
interface coin_return_dispenser_if #(
    parameter int unsigned kNumCoins  = 3,
    parameter int unsigned kNumItems  = 4,
    parameter int unsigned kTotalBits = 31
);
    logic [kNumCoins-1:0]  i_input_coin;
    logic [kNumItems-1:0]  i_select_item;
    logic                  i_trigger_return;
    logic [kTotalBits-1:0] i_balance;
    logic [31:0]           o_wait_time;
    logic [kNumCoins-1:0]  o_return_coin;
    logic                  o_returning;
    logic                  o_return_done;
    logic [kTotalBits-1:0] o_residual;

    modport master (
        output i_input_coin,
        output i_select_item,
        output i_trigger_return,
        output i_balance,
        input  o_wait_time,
        input  o_return_coin,
        input  o_returning,
        input  o_return_done,
        input  o_residual
    );

    modport slave (
        input  i_input_coin,
        input  i_select_item,
        input  i_trigger_return,
        input  i_balance,
        output o_wait_time,
        output o_return_coin,
        output o_returning,
        output o_return_done,
        output o_residual
    );
endinterface

// File: rtl/coin_return_dispenser.sv
// Coin return stage: owns the inactivity timer and, once a return is triggered by the button
// or by timeout, pays out the latched balance greedily, one coin per cycle.
module coin_return_dispenser #(
    parameter int unsigned kNumCoins   = 3,
    parameter int unsigned kNumItems   = 4,
    parameter int unsigned kTotalBits  = 31,
    parameter int unsigned COIN0_VALUE = 100,
    parameter int unsigned COIN1_VALUE = 500,
    parameter int unsigned COIN2_VALUE = 1000,
    parameter int unsigned WAIT_CYCLES = 100
) (
    input logic                    clk,
    input logic                    reset_n,
    coin_return_dispenser_if.slave bus
);

    localparam logic [kTotalBits-1:0] Coin0Val  = kTotalBits'(COIN0_VALUE);
    localparam logic [kTotalBits-1:0] Coin1Val  = kTotalBits'(COIN1_VALUE);
    localparam logic [kTotalBits-1:0] Coin2Val  = kTotalBits'(COIN2_VALUE);
    localparam logic [31:0]           WaitLoad  = 32'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StDispense, StDone} state_e;

    // Local copies of the bus inputs, sized by this block's own parameters.
    logic [kNumCoins-1:0]  input_coin;
    logic [kNumItems-1:0]  select_item;
    logic                  trigger_return;
    logic [kTotalBits-1:0] balance;

    assign input_coin     = bus.i_input_coin;
    assign select_item    = bus.i_select_item;
    assign trigger_return = bus.i_trigger_return;
    assign balance        = bus.i_balance;

    state_e                state_q;
    logic [31:0]           wait_q;
    logic [kNumCoins-1:0]  return_coin_q;
    logic                  return_done_q;
    logic [kTotalBits-1:0] residual_q;
    logic [kTotalBits-1:0] remaining_q;

    logic                  activity;
    logic                  start_return;
    logic                  coin_found;
    logic [kNumCoins-1:0]  coin_sel;
    logic [kTotalBits-1:0] coin_val;

    // Any coin or item strobe counts as customer activity; a coin insert also vetoes a start.
    always_comb begin
        activity     = (|input_coin) || (|select_item);
        start_return = (trigger_return || (wait_q == 32'd0)) && (input_coin == '0);
    end

    // Greedy pick: the largest denomination that still fits in the remaining balance.
    always_comb begin
        coin_found = 1'b0;
        coin_sel   = '0;
        coin_val   = '0;
        if (remaining_q >= Coin2Val) begin
            coin_found  = 1'b1;
            coin_sel[2] = 1'b1;
            coin_val    = Coin2Val;
        end else if (remaining_q >= Coin1Val) begin
            coin_found  = 1'b1;
            coin_sel[1] = 1'b1;
            coin_val    = Coin1Val;
        end else if (remaining_q >= Coin0Val) begin
            coin_found  = 1'b1;
            coin_sel[0] = 1'b1;
            coin_val    = Coin0Val;
        end
    end

    // Return FSM with timer and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            wait_q        <= WaitLoad;
            return_coin_q <= '0;
            return_done_q <= 1'b0;
            residual_q    <= '0;
            remaining_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    return_coin_q <= '0;
                    return_done_q <= 1'b0;
                    if (activity) begin
                        wait_q <= WaitLoad;
                    end else if (wait_q != 32'd0) begin
                        wait_q <= wait_q - 32'd1;
                    end
                    if (start_return) begin
                        remaining_q <= balance;
                        state_q     <= StDispense;
                    end
                end
                StDispense: begin
                    // Timer holds; inputs are ignored until the return completes.
                    if (coin_found) begin
                        return_coin_q <= coin_sel;
                        remaining_q   <= remaining_q - coin_val;
                    end else begin
                        return_coin_q <= '0;
                        residual_q    <= remaining_q;
                        return_done_q <= 1'b1;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    return_done_q <= 1'b0;
                    wait_q        <= WaitLoad;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_wait_time   = wait_q;
    assign bus.o_return_coin = return_coin_q;
    assign bus.o_returning   = (state_q != StIdle);
    assign bus.o_return_done = return_done_q;
    assign bus.o_residual    = residual_q;

    // At most one coin leaves per cycle.
    a_coin_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(return_coin_q));

    // The done pulse only ever appears in the DONE state.
    a_done_state: assert property (@(posedge clk) disable iff (!reset_n)
        return_done_q |-> (state_q == StDone));

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for the coin return stage: a constant vector table, hand-written corner sequences and
// a randomized phase, all checked against a return-schedule model built from the greedy rules.
module tb_coin_return_dispenser;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    coin_return_dispenser_if bus_if ();

    coin_return_dispenser dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: per-return schedule of output slots ----------------
    typedef struct packed {
        logic [2:0] coin;
        logic       done;
    } slot_t;

    slot_t       sched[$];
    int unsigned m_wait;
    logic [2:0]  m_coin;
    logic        m_done;
    logic        m_ret;
    logic        m_busy;
    logic [30:0] m_resid;
    logic [30:0] m_final;

    task automatic model_reset();
        sched.delete();
        m_wait  = 100;
        m_coin  = '0;
        m_done  = 1'b0;
        m_ret   = 1'b0;
        m_busy  = 1'b0;
        m_resid = '0;
        m_final = '0;
    endtask

    // Greedy change by division: thousands, then five-hundreds, then hundreds.
    task automatic plan_return(input int unsigned bal);
        int unsigned r;
        r = bal;
        repeat (r / 1000) sched.push_back('{coin: 3'b100, done: 1'b0});
        r = r % 1000;
        repeat (r / 500) sched.push_back('{coin: 3'b010, done: 1'b0});
        r = r % 500;
        repeat (r / 100) sched.push_back('{coin: 3'b001, done: 1'b0});
        r = r % 100;
        sched.push_back('{coin: 3'b000, done: 1'b1});
        m_final = 31'(r);
    endtask

    task automatic model_edge();
        slot_t s;
        logic  start;
        if (sched.size() != 0) begin
            s      = sched.pop_front();
            m_coin = s.coin;
            m_done = s.done;
            if (s.done) m_resid = m_final;
        end else if (m_busy) begin
            m_busy = 1'b0;
            m_ret  = 1'b0;
            m_coin = '0;
            m_done = 1'b0;
            m_wait = 100;
        end else begin
            start  = (bus_if.i_trigger_return || m_wait == 0) && (bus_if.i_input_coin == 3'b000);
            m_coin = '0;
            m_done = 1'b0;
            if (bus_if.i_input_coin != 3'b000 || bus_if.i_select_item != 4'h0) m_wait = 100;
            else if (m_wait > 0) m_wait = m_wait - 1;
            if (start) begin
                plan_return(32'(bus_if.i_balance));
                m_busy = 1'b1;
                m_ret  = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("model_wait",   64'(bus_if.o_wait_time),   64'(m_wait));
        chk("model_coin",   64'(bus_if.o_return_coin), 64'(m_coin));
        chk("model_done",   64'(bus_if.o_return_done), 64'(m_done));
        chk("model_ret",    64'(bus_if.o_returning),   64'(m_ret));
        chk("model_resid",  64'(bus_if.o_residual),    64'(m_resid));
    endtask

    // One clock: advance model with current inputs, then sample DUT just after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_in(input logic [2:0] coin, input logic [3:0] sel, input logic trig,
                          input logic [30:0] bal);
        bus_if.i_input_coin     = coin;
        bus_if.i_select_item    = sel;
        bus_if.i_trigger_return = trig;
        bus_if.i_balance        = bal;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wait"},  64'(bus_if.o_wait_time),   64'd100);
        chk({tag, "_coin"},  64'(bus_if.o_return_coin), 64'd0);
        chk({tag, "_done"},  64'(bus_if.o_return_done), 64'd0);
        chk({tag, "_ret"},   64'(bus_if.o_returning),   64'd0);
        chk({tag, "_resid"}, 64'(bus_if.o_residual),    64'd0);
    endtask

    // ---------------- constant vector table ----------------
    typedef struct packed {
        logic [2:0]  coin;
        logic [3:0]  sel;
        logic        trig;
        logic [30:0] bal;
        logic [2:0]  e_coin;
        logic        e_done;
        logic        e_ret;
        logic [31:0] e_wait;
        logic [30:0] e_resid;
    } vec_t;

    vec_t tbl [0:9];

    initial begin
        int          done_cnt;
        int unsigned coin_sum;
        int          coin_cnt;
        bit          hit;

        // 1600 return from a fresh timer: start edge also ticks the timer to 99.
        tbl[0] = '{3'b000, 4'h0, 1'b1, 31'd1600, 3'b000, 1'b0, 1'b1, 32'd99,  31'd0};
        tbl[1] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b100, 1'b0, 1'b1, 32'd99,  31'd0};
        tbl[2] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b010, 1'b0, 1'b1, 32'd99,  31'd0};
        tbl[3] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b001, 1'b0, 1'b1, 32'd99,  31'd0};
        tbl[4] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b000, 1'b1, 1'b1, 32'd99,  31'd0};
        tbl[5] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b000, 1'b0, 1'b0, 32'd100, 31'd0};
        tbl[6] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b000, 1'b0, 1'b0, 32'd99,  31'd0};
        // Coin insert on the trigger edge wins; select reloads; idle decrements.
        tbl[7] = '{3'b001, 4'h0, 1'b1, 31'd900,  3'b000, 1'b0, 1'b0, 32'd100, 31'd0};
        tbl[8] = '{3'b000, 4'h2, 1'b0, 31'd0,    3'b000, 1'b0, 1'b0, 32'd100, 31'd0};
        tbl[9] = '{3'b000, 4'h0, 1'b0, 31'd0,    3'b000, 1'b0, 1'b0, 32'd99,  31'd0};

        set_in(3'b000, 4'h0, 1'b0, 31'd0);
        do_reset();
        #1;
        check_reset_vals("reset");

        // Table phase.
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].coin, tbl[i].sel, tbl[i].trig, tbl[i].bal);
            tick();
            chk($sformatf("tbl%0d_coin", i),  64'(bus_if.o_return_coin), 64'(tbl[i].e_coin));
            chk($sformatf("tbl%0d_done", i),  64'(bus_if.o_return_done), 64'(tbl[i].e_done));
            chk($sformatf("tbl%0d_ret", i),   64'(bus_if.o_returning),   64'(tbl[i].e_ret));
            chk($sformatf("tbl%0d_wait", i),  64'(bus_if.o_wait_time),   64'(tbl[i].e_wait));
            chk($sformatf("tbl%0d_resid", i), 64'(bus_if.o_residual),    64'(tbl[i].e_resid));
        end

        // Idle timeout: 100 quiet edges to zero, then an empty return.
        set_in(3'b000, 4'h0, 1'b0, 31'd0);
        do_reset();
        repeat (100) tick();
        chk("timeout_wait_zero", 64'(bus_if.o_wait_time), 64'd0);
        chk("timeout_not_ret", 64'(bus_if.o_returning), 64'd0);
        tick();
        chk("timeout_start_ret", 64'(bus_if.o_returning), 64'd1);
        chk("timeout_wait_hold", 64'(bus_if.o_wait_time), 64'd0);
        tick();
        chk("timeout_done", 64'(bus_if.o_return_done), 64'd1);
        chk("timeout_nocoin", 64'(bus_if.o_return_coin), 64'd0);
        chk("timeout_resid", 64'(bus_if.o_residual), 64'd0);
        tick();
        chk("timeout_reload", 64'(bus_if.o_wait_time), 64'd100);

        // 2750 return, with balance changes and coin toggles while dispensing.
        set_in(3'b000, 4'h0, 1'b1, 31'd2750);
        tick();
        coin_sum = 0;
        coin_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(3'(i % 2), 4'h0, 1'b0, 31'(i * 300));
            tick();
            if (bus_if.o_return_coin != 3'b000) begin
                coin_cnt++;
                coin_sum += (bus_if.o_return_coin == 3'b100) ? 1000 :
                            (bus_if.o_return_coin == 3'b010) ? 500 : 100;
            end
        end
        chk("r2750_count", 64'(coin_cnt), 64'd5);
        chk("r2750_sum", 64'(coin_sum), 64'd2700);
        chk("r2750_resid", 64'(bus_if.o_residual), 64'd50);

        // Select pulse when the timer reads 40 reloads it.
        set_in(3'b000, 4'h0, 1'b0, 31'd0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.o_wait_time == 32'd40) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("wait40_reached", 64'(hit), 64'd1);
        set_in(3'b000, 4'h8, 1'b0, 31'd0);
        tick();
        chk("select_reload", 64'(bus_if.o_wait_time), 64'd100);

        // Asynchronous reset after the second coin of a 2750 return.
        set_in(3'b000, 4'h0, 1'b1, 31'd2750);
        tick();
        set_in(3'b000, 4'h0, 1'b0, 31'd0);
        tick();
        tick();
        chk("abort_second_coin", 64'(bus_if.o_return_coin), 64'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("abort_idle", 64'(bus_if.o_returning), 64'd0);

        // Trigger held high with zero balance: an empty return every third cycle.
        set_in(3'b000, 4'h0, 1'b1, 31'd0);
        done_cnt = 0;
        repeat (9) begin
            tick();
            if (bus_if.o_return_done) done_cnt++;
        end
        chk("retrigger_done_count", 64'(done_cnt), 64'd3);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 15) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000,
                   ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                   ($urandom_range(0, 7) == 0),
                   31'($urandom_range(0, 6000)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
